// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Shared types and helpers for the sliding DCT datapath.
//   slide_state_t : window-fill state of the sliding_sum accumulator
//   acc_width()   : accumulator width needed to sum N samples of L bits
//   round_const() : round-half-up offset applied before a right shift by w
// No ports (package).
// ---------------------------------------------------------------------------
package dct_pkg;

  // FILL: window not yet full since the last clear; RUN: full window tracked.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } slide_state_t;

  // Summing N values of L bits needs $clog2(N) extra bits of headroom.
  function automatic int acc_width(input int l, input int n);
    return l + $clog2(n);
  endfunction

  // Half of one LSB after shifting right by w; zero when nothing is shifted.
  function automatic int round_const(input int w);
    return (w > 0) ? (1 << (w - 1)) : 0;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// ---------------------------------------------------------------------------
// frame_counter
// Modulo-N counter with enable, synchronous clear and a wrap indication.
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous active-high clear (count -> 0)
//   en    in   advance the count this cycle
//   count out  current count, 0..N-1
//   wrap  out  high in the cycle where an enabled count steps N-1 -> 0
// ---------------------------------------------------------------------------
module frame_counter #(
  parameter  int N  = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  // Wrap is combinational so the owner can register a pulse on the same
  // edge where the count returns to zero.
  assign wrap = en && (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sliding_sum.sv
// ---------------------------------------------------------------------------
// sliding_sum
// Moving-window accumulator: S(n) = S(n-1) + x(n) - x(n-N).
// x_old comes from the paired delay-line shifter (delay N). While the window
// is filling after a clear, x_old is ignored so a shifter holding stale data
// cannot corrupt the first sums.
// Ports:
//   clk         in   rising-edge clock, one sample per cycle
//   clr         in   synchronous active-high clear (also clears the shifter)
//   x_new       in   current sample x(n), signed L bits
//   x_old       in   delayed sample x(n-N), signed L bits
//   y           out  registered window sum (or mean), signed L+W bits
//   y_valid     out  y covers a full window of N samples
//   frame_start out  pulse on the first valid output and every N cycles after
// Configuration:
//   DCT_SLIDE_AVG_EN  when defined, y carries the rounded window mean
//                     (requires N to be a power of two).
// ---------------------------------------------------------------------------
module sliding_sum
  import dct_pkg::*;
#(
  parameter  int N = 8,
  parameter  int L = 32,
  localparam int W = $clog2(N)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic signed [L-1:0] x_new,
  input  logic signed [L-1:0] x_old,
  output logic signed [L+W-1:0] y,
  output logic                y_valid,
  output logic                frame_start
);

  localparam int AW = acc_width(L, N);

  if (N < 2) begin : g_bad_n
    $error("sliding_sum: N must be at least 2");
  end

  slide_state_t state, state_next;

  logic          fill_en, phase_en, fill_done;
  logic          fill_wrap, phase_wrap;
  logic [W-1:0]  fill_cnt, phase_cnt;

  logic signed [AW-1:0] new_ext, old_ext, acc, acc_next, y_next;

  // fill_cnt counts samples accumulated since the clear; its wrap marks the
  // N-th sample and therefore the FILL->RUN edge.
  frame_counter #(.N(N)) u_fill_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (fill_en),
    .count (fill_cnt),
    .wrap  (fill_wrap)
  );

  // phase_cnt stays at zero through FILL, so its first wrap lands exactly N
  // cycles after the first valid output.
  frame_counter #(.N(N)) u_phase_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (phase_en),
    .count (phase_cnt),
    .wrap  (phase_wrap)
  );

  // The counts themselves are kept for debug visibility only.
  logic unused_cnt;
  assign unused_cnt = ^{fill_cnt, phase_cnt};

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fill_en    = 1'b0;
    phase_en   = 1'b0;
    fill_done  = 1'b0;
    case (state)
      FILL: begin
        fill_en = 1'b1;
        if (fill_wrap) begin
          fill_done  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        phase_en = 1'b1;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Both operands are sign-extended to the full accumulator width, which has
  // enough headroom that the window sum can never overflow.
  always_comb begin
    new_ext  = {{W{x_new[L-1]}}, x_new};
    old_ext  = (state == RUN) ? {{W{x_old[L-1]}}, x_old} : '0;
    acc_next = acc + new_ext - old_ext;
  end

`ifdef DCT_SLIDE_AVG_EN
  if ((N & (N - 1)) != 0) begin : g_bad_avg_n
    $error("sliding_sum: DCT_SLIDE_AVG_EN requires N to be a power of two");
  end

  // Round-half-up mean: the arithmetic shift keeps the sign bits, so the
  // result is already sign-extended back to the full width. The added
  // offset cannot overflow because the sum is below N * 2^(L-1) in magnitude.
  always_comb begin
    y_next = (acc_next + AW'(round_const(W))) >>> W;
  end
`else
  always_comb begin
    y_next = acc_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      acc         <= '0;
      y           <= '0;
      y_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      acc         <= acc_next;
      y           <= y_next;
      if (fill_done) begin
        y_valid <= 1'b1;
      end
      frame_start <= fill_done | phase_wrap;
    end
  end

endmodule

// File: doc/sliding_sum.md
# sliding_sum

Moving-window accumulator stage directly downstream of the delay-line shifter in the sliding DCT datapath. Consumes the live sample x(n) and the shifter's delayed sample x(n−N), and maintains the running window sum S(n) = S(n−1) + x(n) − x(n−N). It tracks window fill after a clear, flags when the sum is valid, and marks N-sample frame boundaries for the twiddle/rotation stage that follows.

## Interface
- N, 8: window length in samples; the paired shifter is instantiated with shift = N−1, which delays by N cycles. Minimum 2.
- L, 32: sample width, two's-complement signed.
- W, $clog2(N): growth bits, derived localparam, not overridable.
- Clock is `clk`; reset is `clr`, synchronous and active-high, single clock domain.
- clk  in  1  rising-edge clock; one sample is consumed every cycle, with no stall.
- clr  in  1  synchronous, active-high clear; when sampled high it clears this block and the paired shifter together.
- x_new  in  L  current sample x(n), signed.
- x_old  in  L  delayed sample x(n−N), taken from the shifter output `b`, signed.
- y  out  L+W  registered window sum, signed.
- y_valid  out  1  high when y covers a full window of N samples.
- frame_start  out  1  one-cycle pulse on the first valid output and every N cycles after.

## Operation
- FSM states are FILL and RUN.
  - clr forces FILL.
  - FILL→RUN on the edge that accumulates the N-th sample after clr, when fill_cnt == N−1.
  - RUN holds until clr.
- fill_cnt, 0..N−1, increments every cycle in FILL and is frozen in RUN.
- In FILL, x_old is ignored and treated as 0. This makes the block robust to a shifter that is not zero after reset.
- Accumulator width is L+W, signed.
  - Both operands are sign-extended to L+W before the add and subtract.
  - The sum of any N L-bit values fits in L+W bits, so the accumulator can never overflow.
- y_valid is low in FILL. It goes high on the FILL→RUN edge and stays high until clr.
- phase_cnt, 0..N−1:
  - resets to 0 and is held in FILL;
  - increments modulo N in RUN.
  - frame_start = 1 on the FILL→RUN edge and whenever phase_cnt wraps N−1→0.
- clr takes priority over everything in the same cycle. The input sample in that cycle is discarded.

## Timing
- Reset values: y = 0, y_valid = 0, frame_start = 0, acc = 0, state = FILL, fill_cnt = 0, phase_cnt = 0.
- Latency is 1 cycle. The sample present at edge k is included in y after edge k.
- The first valid output appears N edges after clr deasserts. From then on there is one valid output per cycle.
- clr mid-run: outputs return to reset values on the next edge, and the full N-cycle fill repeats.
- Steady-state throughput is 1 sample per clock, with no bubbles.

## Configuration
- Macro `DCT_SLIDE_AVG_EN`: when defined, y carries the window mean instead of the raw sum.
  - The mean is acc arithmetically shifted right by W, with round-half-up (add 2^(W−1) before the shift).
  - The result is sign-extended back to L+W bits.
  - N must be a power of two; an elaboration-time check rejects other values.
- When the macro is undefined, y = acc unchanged. The port width is the same in both builds.

## Structure
- Package `dct_pkg` holds:
  - the state enum {FILL, RUN};
  - the function acc_width(L, N) = L + $clog2(N);
  - the round constant helper used by the averaging option.
- Sub-module `frame_counter`: modulo-N counter with enable, synchronous clear and a wrap pulse. It is used for phase_cnt, and fill_cnt may reuse it.
- Integration does not instantiate the shifter inside this block. The parent wires shifter `b` to x_old and drives both blocks from the same `clr`.

## Test plan
All scenarios use N=4 and L=8, with x_old driven from shifter shift=3.
- Constant fill: clr, then x_new=1 continuously → y = 1, 2, 3, 4, 4, 4…; y_valid rises with y=4; frame_start pulses at the 4th, 8th and 12th outputs.
- Impulse: x_new = 5 for one cycle, then 0 → y = 5 for exactly 4 cycles, then 0.
- Negative extreme: x_new = −128 continuously → y settles at −512 with no wrap. At the positive extreme, 127 → y = 508.
- Mid-run clear: after 6 samples, clr is high for one cycle together with x_new=100 → y=0, y_valid=0, frame_start=0; the sample of 100 is ignored; refill takes 4 cycles.
- Dirty shifter: x_old forced to 7 during FILL → the FILL sums are unaffected, and y matches the constant-fill case.
- With `DCT_SLIDE_AVG_EN`: inputs 1, 2, 1, 2 give sum 6 → y=2 (1.5 rounded up); constant −3 gives y=−3; inputs −1, −2, −1, −2 give sum −6 → y=−1.
